// File: rtl/regfile_sb.sv
// Register file with a per-register scoreboard (busy bits) for in-order issue.
// After reset a sweep zeroes every register before operations are accepted.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            ready,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rv1,
   output logic [XLEN-1:0] rv2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            we,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wd,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            busy_any
);

   typedef enum logic {INIT, RUN} state_t;

   state_t          state;
   logic [AW-1:0]   cnt;
   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic            wr_en;
   logic            iss_en;

   assign wr_en  = ready && we && (rd != '0);
   assign iss_en = ready && iss_valid && (iss_rd != '0);

   // Issue is applied after writeback so a same-index collision leaves busy set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
         ready <= 1'b0;
         busy  <= '0;
      end else if (state == INIT) begin
         cnt  <= cnt + 1'b1;
         busy <= '0;
         if (cnt == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end else begin
         if (wr_en)
            busy[rd] <= 1'b0;
         if (iss_en)
            busy[iss_rd] <= 1'b1;
      end
   end

   // The array has no reset of its own; the sweep is what clears it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT)
            regs[cnt] <= '0;
         else if (wr_en)
            regs[rd] <= wd;
      end
   end

   always_comb begin
      rv1 = '0;
      rv2 = '0;
      if (ready && (rs1 != '0))
         rv1 = (we && (rd == rs1)) ? wd : regs[rs1];
      if (ready && (rs2 != '0))
         rv2 = (we && (rd == rs2)) ? wd : regs[rs2];
   end

   // A writeback landing this cycle hides the pending state from the reader.
   assign rs1_busy = ready && busy[rs1] && !(wr_en && (rd == rs1));
   assign rs2_busy = ready && busy[rs2] && !(wr_en && (rd == rs2));
   assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, corner sequences and
// randomized traffic against an array-based model, plus two extra parameter sets.
module tb_regfile_sb;

   localparam int XLEN    = 32;
   localparam int NREGS   = 32;
   localparam int AW      = $clog2(NREGS);
   localparam int A_XLEN  = 64;
   localparam int A_NREGS = 16;
   localparam int A_AW    = $clog2(A_NREGS);
   localparam int B_XLEN  = 32;
   localparam int B_NREGS = 64;
   localparam int B_AW    = $clog2(B_NREGS);

   logic            clk;
   logic            rst_n;
   logic            ready;
   logic [AW-1:0]   rs1, rs2, rd, iss_rd;
   logic [XLEN-1:0] rv1, rv2, wd;
   logic            rs1_busy, rs2_busy, we, iss_valid, busy_any;

   logic              a_ready, a_rs1_busy, a_rs2_busy, a_we, a_iss_valid, a_busy_any;
   logic [A_AW-1:0]   a_rs1, a_rs2, a_rd, a_iss_rd;
   logic [A_XLEN-1:0] a_rv1, a_rv2, a_wd;

   logic              b_ready, b_rs1_busy, b_rs2_busy, b_we, b_iss_valid, b_busy_any;
   logic [B_AW-1:0]   b_rs1, b_rs2, b_rd, b_iss_rd;
   logic [B_XLEN-1:0] b_rv1, b_rv2, b_wd;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) u_dut (
      .clk(clk), .rst_n(rst_n), .ready(ready), .rs1(rs1), .rs2(rs2),
      .rv1(rv1), .rv2(rv2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .we(we), .rd(rd), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy_any(busy_any));

   regfile_sb #(.XLEN(A_XLEN), .NREGS(A_NREGS)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ready(a_ready), .rs1(a_rs1), .rs2(a_rs2),
      .rv1(a_rv1), .rv2(a_rv2), .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
      .we(a_we), .rd(a_rd), .wd(a_wd), .iss_valid(a_iss_valid), .iss_rd(a_iss_rd),
      .busy_any(a_busy_any));

   regfile_sb #(.XLEN(B_XLEN), .NREGS(B_NREGS)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ready(b_ready), .rs1(b_rs1), .rs2(b_rs2),
      .rv1(b_rv1), .rv2(b_rv2), .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
      .we(b_we), .rd(b_rd), .wd(b_wd), .iss_valid(b_iss_valid), .iss_rd(b_iss_rd),
      .busy_any(b_busy_any));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int testsRun  = 0;
   int failCount = 0;

   // Reference model: plain arrays, ready derived from edges counted since reset.
   logic [XLEN-1:0] mRegs [NREGS];
   bit              mBusy [NREGS];
   int              mEdges = 0;
   bit              mReady = 0;

   typedef struct {
      bit          we;
      int          rd;
      logic [63:0] wd;
      bit          iss;
      int          issRd;
      int          rs1;
      int          rs2;
      logic [63:0] eRv1;
      logic [63:0] eRv2;
      bit          eB1;
      bit          eB2;
      bit          eAny;
   } vec_t;

   vec_t vecs [16];

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic modelUpdate();
      if (!rst_n) begin
         mEdges = 0;
         mReady = 0;
         foreach (mBusy[i]) mBusy[i] = 0;
      end else if (!mReady) begin
         mEdges++;
         if (mEdges == NREGS) begin
            mReady = 1;
            foreach (mRegs[i]) mRegs[i] = '0;
         end
      end else begin
         if (we && rd != 0) begin
            mRegs[rd] = wd;
            mBusy[rd] = 0;
         end
         if (iss_valid && iss_rd != 0)
            mBusy[iss_rd] = 1;
      end
   endtask

   function automatic logic [63:0] expRv(input int idx);
      if (!mReady || idx == 0) return 64'd0;
      if (we && int'(rd) == idx) return 64'(wd);
      return 64'(mRegs[idx]);
   endfunction

   function automatic logic [63:0] expBusy(input int idx);
      if (!mReady) return 64'd0;
      if (we && idx != 0 && int'(rd) == idx) return 64'd0;
      return 64'(mBusy[idx]);
   endfunction

   function automatic logic [63:0] expAny();
      foreach (mBusy[i]) if (mBusy[i]) return 64'd1;
      return 64'd0;
   endfunction

   function automatic int randIdx();
      if ($urandom_range(0, 1) != 0) return int'($urandom_range(0, 3));
      return int'($urandom_range(0, NREGS - 1));
   endfunction

   task automatic cycle();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t v);
      we        = v.we;
      rd        = AW'(v.rd);
      wd        = XLEN'(v.wd);
      iss_valid = v.iss;
      iss_rd    = AW'(v.issRd);
      rs1       = AW'(v.rs1);
      rs2       = AW'(v.rs2);
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".ready"}, 64'(ready), 64'(mReady));
      checkVal({tag, ".rv1"}, 64'(rv1), expRv(int'(rs1)));
      checkVal({tag, ".rv2"}, 64'(rv2), expRv(int'(rs2)));
      checkVal({tag, ".rs1_busy"}, 64'(rs1_busy), expBusy(int'(rs1)));
      checkVal({tag, ".rs2_busy"}, 64'(rs2_busy), expBusy(int'(rs2)));
      checkVal({tag, ".busy_any"}, 64'(busy_any), expAny());
   endtask

   task automatic clearInputs();
      we = 0; rd = '0; wd = '0; iss_valid = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
      a_we = 0; a_rd = '0; a_wd = '0; a_iss_valid = 0; a_iss_rd = '0; a_rs1 = '0; a_rs2 = '0;
      b_we = 0; b_rd = '0; b_wd = '0; b_iss_valid = 0; b_iss_rd = '0; b_rs1 = '0; b_rs2 = '0;
   endtask

   initial begin
      int lowMain, lowA, lowB, guard;

      //            we rd  wd            iss ird rs1 rs2 eRv1          eRv2   eB1 eB2 eAny
      vecs[0]  = '{1, 5,  64'hDEADBEEF, 0, 0,  5,  0,  64'hDEADBEEF, 64'h0,  0, 0, 0};
      vecs[1]  = '{0, 0,  64'h0,        0, 0,  5,  7,  64'hDEADBEEF, 64'h0,  0, 0, 0};
      vecs[2]  = '{0, 0,  64'h0,        1, 7,  5,  7,  64'hDEADBEEF, 64'h0,  0, 0, 0};
      vecs[3]  = '{0, 0,  64'h0,        0, 0,  0,  7,  64'h0,        64'h0,  0, 1, 1};
      vecs[4]  = '{1, 7,  64'h77,       0, 0,  0,  7,  64'h0,        64'h77, 0, 0, 1};
      vecs[5]  = '{0, 0,  64'h0,        0, 0,  0,  7,  64'h0,        64'h77, 0, 0, 0};
      vecs[6]  = '{1, 9,  64'h99,       1, 9,  9,  7,  64'h99,       64'h77, 0, 0, 0};
      vecs[7]  = '{0, 0,  64'h0,        0, 0,  9,  0,  64'h99,       64'h0,  1, 0, 1};
      vecs[8]  = '{1, 0,  64'hFFFF,     1, 0,  0,  0,  64'h0,        64'h0,  0, 0, 1};
      vecs[9]  = '{0, 0,  64'h0,        0, 0,  0,  9,  64'h0,        64'h99, 0, 1, 1};
      vecs[10] = '{1, 12, 64'hAA,       1, 13, 12, 13, 64'hAA,       64'h0,  0, 0, 1};
      vecs[11] = '{0, 0,  64'h0,        0, 0,  12, 13, 64'hAA,       64'h0,  0, 1, 1};
      vecs[12] = '{1, 20, 64'h2020,     0, 0,  20, 13, 64'h2020,     64'h0,  0, 1, 1};
      vecs[13] = '{0, 0,  64'h0,        0, 0,  20, 9,  64'h2020,     64'h99, 0, 1, 1};
      vecs[14] = '{1, 9,  64'h1111,     0, 0,  9,  13, 64'h1111,     64'h0,  0, 1, 1};
      vecs[15] = '{0, 0,  64'h0,        0, 0,  9,  13, 64'h1111,     64'h0,  0, 1, 1};

      rst_n = 0;
      clearInputs();
      @(negedge clk);
      for (int i = 0; i < 3; i++) cycle();
      rst_n = 1;

      // Initial sweep: writes attempted during INIT must be dropped.
      we = 1; rd = AW'(5); wd = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = AW'(6); rs1 = AW'(5);
      #1 checkVal("init_rv1_zero", 64'(rv1), 64'd0);
      checkVal("init_busy_any", 64'(busy_any), 64'd0);
      lowMain = 0; lowA = 0; lowB = 0; guard = 0;
      while ((!ready || !a_ready || !b_ready) && guard < 200) begin
         if (ready) begin we = 0; iss_valid = 0; end
         #1;
         if (!ready) lowMain++;
         if (!a_ready) lowA++;
         if (!b_ready) lowB++;
         cycle();
         guard++;
      end
      checkVal("ready_latency", 64'(lowMain), 64'(NREGS));
      checkVal("ready_latency_a", 64'(lowA), 64'(A_NREGS));
      checkVal("ready_latency_b", 64'(lowB), 64'(B_NREGS));
      clearInputs();

      for (int i = 0; i < NREGS; i++) begin
         rs1 = AW'(i);
         rs2 = AW'(NREGS - 1 - i);
         #1;
         checkVal($sformatf("post_reset_rv1[%0d]", i), 64'(rv1), 64'd0);
         checkVal($sformatf("post_reset_rv2[%0d]", i), 64'(rv2), 64'd0);
      end
      checkVal("post_reset_ready", 64'(ready), 64'd1);
      checkVal("post_reset_busy_any", 64'(busy_any), 64'd0);

      // Other parameter sets: bypass, array read and busy lifecycle.
      a_we = 1; a_rd = A_AW'(5); a_wd = 64'hDEADBEEF_CAFEF00D; a_rs1 = A_AW'(5);
      a_iss_valid = 1; a_iss_rd = A_AW'(7); a_rs2 = A_AW'(7);
      b_we = 1; b_rd = B_AW'(40); b_wd = 32'hDEADBEEF; b_rs1 = B_AW'(40);
      b_iss_valid = 1; b_iss_rd = B_AW'(63); b_rs2 = B_AW'(63);
      #1;
      checkVal("a_bypass", 64'(a_rv1), 64'hDEADBEEF_CAFEF00D);
      checkVal("b_bypass", 64'(b_rv1), 64'hDEADBEEF);
      checkVal("a_busy_before", 64'(a_rs2_busy), 64'd0);
      cycle();
      a_we = 0; a_iss_valid = 0; b_we = 0; b_iss_valid = 0;
      #1;
      checkVal("a_array_read", 64'(a_rv1), 64'hDEADBEEF_CAFEF00D);
      checkVal("b_array_read", 64'(b_rv1), 64'hDEADBEEF);
      checkVal("a_rs2_busy", 64'(a_rs2_busy), 64'd1);
      checkVal("b_rs2_busy", 64'(b_rs2_busy), 64'd1);
      checkVal("a_busy_any", 64'(a_busy_any), 64'd1);
      checkVal("b_busy_any", 64'(b_busy_any), 64'd1);
      a_we = 1; a_rd = A_AW'(7); a_wd = 64'h1;
      b_we = 1; b_rd = B_AW'(63); b_wd = 32'h1;
      #1;
      checkVal("a_busy_hidden", 64'(a_rs2_busy), 64'd0);
      checkVal("b_busy_hidden", 64'(b_rs2_busy), 64'd0);
      cycle();
      a_we = 0; b_we = 0;
      #1;
      checkVal("a_busy_any_clear", 64'(a_busy_any), 64'd0);
      checkVal("b_busy_any_clear", 64'(b_busy_any), 64'd0);
      clearInputs();

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkVal($sformatf("vec%0d.rv1", i), 64'(rv1), vecs[i].eRv1);
         checkVal($sformatf("vec%0d.rv2", i), 64'(rv2), vecs[i].eRv2);
         checkVal($sformatf("vec%0d.rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].eB1));
         checkVal($sformatf("vec%0d.rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].eB2));
         checkVal($sformatf("vec%0d.busy_any", i), 64'(busy_any), 64'(vecs[i].eAny));
         cycle();
      end
      clearInputs();

      // Mid-run reset: pending busy and data on r3 must vanish.
      we = 1; rd = AW'(3); wd = 32'h1234; iss_valid = 1; iss_rd = AW'(3);
      cycle();
      clearInputs();
      rs1 = AW'(3);
      #1;
      checkVal("midrst_pre_rv1", 64'(rv1), 64'h1234);
      checkVal("midrst_pre_busy", 64'(rs1_busy), 64'd1);
      rst_n = 0;
      cycle();
      rst_n = 1;
      we = 1; rd = AW'(3); wd = 32'h5555; iss_valid = 1; iss_rd = AW'(3);
      #1;
      checkVal("midrst_init_rv1", 64'(rv1), 64'd0);
      checkVal("midrst_init_busy_any", 64'(busy_any), 64'd0);
      lowMain = 0; guard = 0;
      while (!ready && guard < 200) begin
         #1 lowMain++;
         cycle();
         guard++;
      end
      checkVal("midrst_latency", 64'(lowMain), 64'(NREGS));
      we = 0; iss_valid = 0;
      #1;
      checkVal("midrst_rv1", 64'(rv1), 64'd0);
      checkVal("midrst_busy", 64'(rs1_busy), 64'd0);
      checkVal("midrst_busy_any", 64'(busy_any), 64'd0);
      clearInputs();

      // Randomized traffic with occasional resets, compared against the model.
      for (int n = 0; n < 600; n++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         we        = $urandom_range(0, 1) != 0;
         rd        = AW'(randIdx());
         wd        = XLEN'($urandom);
         iss_valid = $urandom_range(0, 2) == 0;
         iss_rd    = ($urandom_range(0, 3) == 0) ? rd : AW'(randIdx());
         rs1       = ($urandom_range(0, 2) == 0) ? rd : AW'(randIdx());
         rs2       = ($urandom_range(0, 2) == 0) ? iss_rd : AW'(randIdx());
         #1 checkOutput($sformatf("rand%0d", n));
         cycle();
      end
      rst_n = 1;
      clearInputs();

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, number of architectural registers; legal values are powers of two from 2 to 256.
REQ-003 The block SHALL have parameter AW, default $clog2(NREGS), register index width.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; clk and rst_n are listed first.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 ready  output  1  high once the initialisation sweep is done; operations are accepted only while ready is high.
REQ-008 rs1, rs2  input  AW  read-port register indices.
REQ-009 rv1, rv2  output  XLEN  read-port data.
REQ-010 rs1_busy, rs2_busy  output  1  a write to the indexed register is still pending.
REQ-011 we  input  1  writeback valid.
REQ-012 rd  input  AW  writeback index.
REQ-013 wd  input  XLEN  writeback data.
REQ-014 iss_valid  input  1  an issued instruction will later write iss_rd.
REQ-015 iss_rd  input  AW  issue destination index.
REQ-016 busy_any  output  1  OR of all busy bits.

Function
REQ-017 State machine states SHALL be INIT and RUN; ready SHALL be 1 exactly when the state is RUN.
REQ-018 INIT behaviour:
- an AW-bit sweep counter SHALL write zero to regs[cnt] on each cycle;
- after regs[NREGS-1] is written, the state SHALL move to RUN;
- ready SHALL rise on the NREGS-th rising edge after rst_n is sampled high.
REQ-019 In INIT, the block SHALL ignore we and iss_valid, drive rv1 and rv2 to 0, and drive all busy outputs to 0.
REQ-020 Register 0 SHALL always read as 0, never be written, and never be busy; issue or write with index 0 SHALL have no effect.
REQ-021 Reads SHALL be combinational with zero latency.
REQ-022 Read value: rvN = 0 if rsN==0; otherwise wd if (we && ready && rd==rsN) (write-through bypass); otherwise regs[rsN].
REQ-023 rsN_busy SHALL equal busy[rsN] AND NOT (we && ready && rd==rsN && rd!=0); a same-cycle writeback hides the pending state.
REQ-024 On a rising edge in RUN with we && rd!=0, regs[rd] SHALL take wd, and busy[rd] SHALL clear.
REQ-025 On a rising edge in RUN with iss_valid && iss_rd!=0, busy[iss_rd] SHALL set.
REQ-026 If we and iss_valid target the same nonzero index in the same cycle, the data SHALL be written and busy SHALL end set (issue wins, new producer).
REQ-027 If we and iss_valid target different indices in the same cycle, both updates SHALL take effect independently.
REQ-028 A writeback to a register that is not busy SHALL still write the data, and busy SHALL remain 0.
REQ-029 busy_any SHALL reflect the registered busy bits only, with no bypass applied.

Reset
REQ-030 While rst_n is low on a rising edge, the block SHALL set state to INIT, sweep counter to 0, all busy bits to 0, and ready to 0.
REQ-031 Asserting reset mid-operation SHALL restart the sweep, and ready SHALL stay low for NREGS cycles after release.
REQ-032 The register array SHALL have no reset other than the sweep.

Verification
REQ-033 Reset and ready: hold rst_n low for 3 cycles, then release (NREGS=32) -> ready is 0 for 32 edges and 1 after; every rsN reads 0; busy_any is 0.
REQ-034 Write then read: write rd=5, wd=0xDEADBEEF -> the same cycle rs1=5 gives 0xDEADBEEF (bypass); the next cycle also gives 0xDEADBEEF (array).
REQ-035 Busy lifecycle: issue iss_rd=7 -> next cycle rs2=7 gives rs2_busy=1 and busy_any=1; writeback rd=7 -> rs2_busy=0 that cycle, busy_any=0 next cycle.
REQ-036 Collisions:
- issue and writeback both on index 9 -> rv=wd next cycle, busy[9]=1;
- any op on index 0 -> rv=0, busy=0.
REQ-037 Mid-run reset: busy[3]=1, regs[3]=0x1234, pulse rst_n low for 1 cycle -> ready=0 for 32 cycles, then rs1=3 gives 0 and not busy; we during INIT is ignored.
REQ-038 Parameter sweep: rerun REQ-033 to REQ-036 with XLEN=64/NREGS=16 and XLEN=32/NREGS=64 -> identical results, with ready latency equal to NREGS.
